rcc_char_decoder: RTL
=====================

# rcc_char_decoder

Receive-side decoder for the results-character-conversion (RCC) output stream. It consumes the ASCII digit characters the RCC emits on `dout`, strobed by `digit_clk` and framed by `dout_flag`, and reconstructs the binary result. It reports length, character, overflow and empty-frame errors. It sits downstream of the RCC block, as the checker/consumer end of the same interface, and feeds the scoreboard and host-readback logic.

## Interface
- `RES_W`, 16: width of the reconstructed binary result.
- `MAX_DIGITS`, 5: maximum number of digit characters accepted per frame.
- `clk` input 1: system clock; all logic on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `digit_clk` input 1: one-`clk`-cycle strobe; `din_char` is valid in that cycle.
- `din_char` input 8: ASCII character, connected to RCC `dout`.
- `frame_flag` input 1: connected to RCC `dout_flag`. 1 = idle / end of frame, 0 = frame in progress.
- `result` output RES_W: decoded value, held until the next frame completes.
- `result_valid` output 1: one-cycle pulse when `result` and the error bits update.
- `err_char` output 1: a non-digit character was received in the last frame.
- `err_len` output 1: more than MAX_DIGITS digits were received.
- `err_ovf` output 1: the value exceeded 2^RES_W−1.
- `err_empty` output 1: the frame closed with zero characters.
- `bad_char` output 8: first offending character of the last frame (0x00 if none).
- `digit_count` output 4: characters accepted in the last completed frame (saturates at 15).
- `busy` output 1: high while in ACCUM.

## Operation
- **Reset values:** `result`=0, `result_valid`=0, all `err_*`=0, `bad_char`=0x00, `digit_count`=0, `busy`=0, `prev_flag`=1, state=SYNC, accumulator=0.
- **FSM states:** SYNC, IDLE, ACCUM.
  - SYNC → IDLE when `frame_flag`=1. This ensures a frame already in progress at reset release is never decoded.
  - IDLE → ACCUM on a falling edge of `frame_flag` (`frame_flag`=0 and `prev_flag`=1). The accumulator, the working error bits and the counter clear on entry.
  - ACCUM → IDLE on a rising edge of `frame_flag` (`frame_flag`=1 and `prev_flag`=0). This is the frame close.
- **Character acceptance:** a character is accepted in any cycle with `digit_clk`=1 and `frame_flag`=0 while in ACCUM, or in the IDLE→ACCUM transition cycle.
  - `digit_clk` with `frame_flag`=1 is ignored.
  - Characters arriving in SYNC are ignored.
- **Digit character (0x30–0x39):**
  - Computes acc = acc*10 + (c−0x30) using RES_W+4 bits internally.
  - If the result exceeds 2^RES_W−1: set `err_ovf` and saturate acc to all-ones.
  - The counter increments on every accepted character.
  - If the counter would exceed MAX_DIGITS: set `err_len`. Further digits are not accumulated but are still counted.
- **Non-digit character:** sets `err_char`. `bad_char` captures the first such character only; acc is unchanged.
- **Frame close with counter=0:** sets `err_empty`.
- **Frame close outputs:** `result` = acc if no error bit is set, else all-ones. Error bits, `bad_char` and `digit_count` update together.
- Error bits are sticky within a frame and held until the next frame close or reset.

## Timing
- `prev_flag` is a one-cycle registered copy of `frame_flag`. Edges are detected in the cycle the new level is first sampled.
- A character accepted at edge N is reflected in acc at edge N; its error bits are visible internally from N+1.
- Frame close is detected at edge N. `result`, the `err_*` bits and `digit_count` update and `result_valid`=1 during cycle N+1 only. Latency from the `frame_flag` rise is 1 clock.
- A `digit_clk` in the same cycle as the `frame_flag` rise is dropped.
- `digit_clk` in the same cycle as the `frame_flag` fall is accepted as the first character.
- Back-to-back frames: a fall on the cycle after a close is legal. The `result_valid` pulse of the previous frame still occurs.
- **Reset mid-frame:** there is no `result_valid` for the aborted frame. The block returns to SYNC and waits for `frame_flag`=1 before decoding the next frame.

## Test plan
- **Basic decode:** frame '1','2','3' (0x31, 0x32, 0x33) → `result`=123, `digit_count`=3, no errors, one `result_valid` pulse 1 cycle after the flag rise.
- **Bounds:** frame "65535" → `result`=0xFFFF with no errors. Frame "65536" → `err_ovf`=1, `result`=0xFFFF.
- **Bad character:** frame '7', 'A', 'B' → `err_char`=1, `bad_char`=0x41, `result`=0xFFFF, `digit_count`=3.
- **Length and empty:**
  - Frame "000012" (6 digits) → `err_len`=1, `digit_count`=6.
  - Flag falls then rises with no strobes → `err_empty`=1, `digit_count`=0.
- **Strobe/edge coincidence:**
  - `digit_clk` with `frame_flag`=1 is ignored.
  - A strobe on the fall cycle is counted.
  - A strobe on the rise cycle is dropped: frame '4','2' with '2' on the rise cycle → `result`=4.
- **Reset mid-frame:** reset is asserted after '9' while `frame_flag` stays 0 → no `result_valid` and all outputs at reset values. The next full frame "8" after flag=1 then a fall → `result`=8.

Source files
------------

// File: rtl/rcc_char_decoder.sv
// rcc_char_decoder
// Consumer end of the RCC character stream: collects ASCII digits strobed by
// digit_clk inside a frame (frame_flag low), rebuilds the binary value and
// reports length, character, overflow and empty-frame errors when the frame
// closes. Starts in SYNC so that a frame already running at reset release is
// never decoded.
module rcc_char_decoder #(
    parameter int RES_W      = 16,
    parameter int MAX_DIGITS = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             digit_clk,
    input  logic [7:0]       din_char,
    input  logic             frame_flag,
    output logic [RES_W-1:0] result,
    output logic             result_valid,
    output logic             err_char,
    output logic             err_len,
    output logic             err_ovf,
    output logic             err_empty,
    output logic [7:0]       bad_char,
    output logic [3:0]       digit_count,
    output logic             busy
);

    // Four guard bits keep acc*10+9 from wrapping before the range check.
    localparam int ACC_W = RES_W + 4;
    localparam logic [ACC_W-1:0] RES_MAX = {{4{1'b0}}, {RES_W{1'b1}}};
    localparam logic [ACC_W-1:0] TEN     = {{(ACC_W-4){1'b0}}, 4'd10};
    localparam logic [3:0]       MAX_CNT = 4'(MAX_DIGITS);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ACCUM = 2'd2
    } state_t;

    // ASCII '0'..'9'
    function automatic logic is_digit(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic             prev_flag_r;
    logic             fall_s;
    logic             rise_s;
    logic             entry_s;
    logic             close_s;
    logic             accept_s;

    // Working (in-frame) state
    logic [RES_W-1:0] acc_r,   acc_next_s,   acc_base_s;
    logic [3:0]       cnt_r,   cnt_next_s,   cnt_base_s;
    logic             wchar_r, wchar_next_s, wchar_base_s;
    logic             wlen_r,  wlen_next_s,  wlen_base_s;
    logic             wovf_r,  wovf_next_s,  wovf_base_s;
    logic [7:0]       wbad_r,  wbad_next_s,  wbad_base_s;
    logic [ACC_W-1:0] prod_s;
    logic             any_err_s;

    // Registered outputs
    logic [RES_W-1:0] result_r;
    logic             result_valid_r;
    logic             err_char_r;
    logic             err_len_r;
    logic             err_ovf_r;
    logic             err_empty_r;
    logic [7:0]       bad_char_r;
    logic [3:0]       digit_count_r;
    logic             busy_r;

    assign fall_s = ~frame_flag & prev_flag_r;
    assign rise_s = frame_flag & ~prev_flag_r;

    // Next-state logic: SYNC waits for idle, IDLE opens on fall, ACCUM closes on rise
    always_comb begin
        state_next_s = state_r;
        entry_s      = 1'b0;
        close_s      = 1'b0;
        case (state_r)
            ST_SYNC: begin
                if (frame_flag) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_SYNC;
                end
            end
            ST_IDLE: begin
                if (fall_s) begin
                    state_next_s = ST_ACCUM;
                    entry_s      = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (rise_s) begin
                    state_next_s = ST_IDLE;
                    close_s      = 1'b1;
                end else begin
                    state_next_s = ST_ACCUM;
                end
            end
            default: begin
                state_next_s = ST_SYNC;
            end
        endcase
    end

    // Frame accumulator: clear on entry, then fold in the accepted character
    always_comb begin
        if (entry_s) begin
            acc_base_s   = '0;
            cnt_base_s   = 4'd0;
            wchar_base_s = 1'b0;
            wlen_base_s  = 1'b0;
            wovf_base_s  = 1'b0;
            wbad_base_s  = 8'h00;
        end else begin
            acc_base_s   = acc_r;
            cnt_base_s   = cnt_r;
            wchar_base_s = wchar_r;
            wlen_base_s  = wlen_r;
            wovf_base_s  = wovf_r;
            wbad_base_s  = wbad_r;
        end

        // A strobe on the rising-flag cycle sees frame_flag=1 and is dropped here.
        accept_s = digit_clk & ~frame_flag & ((state_r == ST_ACCUM) | entry_s);
        prod_s   = ({{4{1'b0}}, acc_base_s} * TEN) + {{(ACC_W-4){1'b0}}, din_char[3:0]};

        acc_next_s   = acc_base_s;
        cnt_next_s   = cnt_base_s;
        wchar_next_s = wchar_base_s;
        wlen_next_s  = wlen_base_s;
        wovf_next_s  = wovf_base_s;
        wbad_next_s  = wbad_base_s;

        if (accept_s) begin
            if (cnt_base_s == 4'd15) begin
                cnt_next_s = 4'd15;
            end else begin
                cnt_next_s = cnt_base_s + 4'd1;
            end
            if (is_digit(din_char)) begin
                if (cnt_base_s >= MAX_CNT) begin
                    // Too many digits: count it but stop accumulating.
                    wlen_next_s = 1'b1;
                end else if (prod_s > RES_MAX) begin
                    wovf_next_s = 1'b1;
                    acc_next_s  = '1;
                end else begin
                    acc_next_s = prod_s[RES_W-1:0];
                end
            end else begin
                wchar_next_s = 1'b1;
                if (!wchar_base_s) begin
                    wbad_next_s = din_char;
                end else begin
                    wbad_next_s = wbad_base_s;
                end
            end
        end else begin
            acc_next_s = acc_base_s;
        end

        any_err_s = wchar_r | wlen_r | wovf_r | (cnt_r == 4'd0);
    end

    // State, edge detector and working registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_SYNC;
            prev_flag_r <= 1'b1;
            acc_r       <= '0;
            cnt_r       <= 4'd0;
            wchar_r     <= 1'b0;
            wlen_r      <= 1'b0;
            wovf_r      <= 1'b0;
            wbad_r      <= 8'h00;
        end else begin
            state_r     <= state_next_s;
            prev_flag_r <= frame_flag;
            acc_r       <= acc_next_s;
            cnt_r       <= cnt_next_s;
            wchar_r     <= wchar_next_s;
            wlen_r      <= wlen_next_s;
            wovf_r      <= wovf_next_s;
            wbad_r      <= wbad_next_s;
        end
    end

    // Frame-close result registers; held between closes, one-cycle valid pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            result_r       <= '0;
            result_valid_r <= 1'b0;
            err_char_r     <= 1'b0;
            err_len_r      <= 1'b0;
            err_ovf_r      <= 1'b0;
            err_empty_r    <= 1'b0;
            bad_char_r     <= 8'h00;
            digit_count_r  <= 4'd0;
            busy_r         <= 1'b0;
        end else begin
            busy_r <= (state_next_s == ST_ACCUM);
            if (close_s) begin
                result_r       <= any_err_s ? {RES_W{1'b1}} : acc_r;
                result_valid_r <= 1'b1;
                err_char_r     <= wchar_r;
                err_len_r      <= wlen_r;
                err_ovf_r      <= wovf_r;
                err_empty_r    <= (cnt_r == 4'd0);
                bad_char_r     <= wbad_r;
                digit_count_r  <= cnt_r;
            end else begin
                result_valid_r <= 1'b0;
            end
        end
    end

    assign result       = result_r;
    assign result_valid = result_valid_r;
    assign err_char     = err_char_r;
    assign err_len      = err_len_r;
    assign err_ovf      = err_ovf_r;
    assign err_empty    = err_empty_r;
    assign bad_char     = bad_char_r;
    assign digit_count  = digit_count_r;
    assign busy         = busy_r;

endmodule
